// File: rtl/vec_accum_pkg.sv
// rtl/vec_accum_pkg.sv - shared FSM state type and memory read latency for vec_accum
package vec_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int RD_LAT = 1;

endpackage

// File: rtl/vec_accum_add.sv
// rtl/vec_accum_add.sv - signed accumulate step; saturates and flags overflow under VEC_ACCUM_SAT_EN
module vec_accum_add #(
  parameter int SIZE_DATA = 16,
  parameter int SIZE_ACC  = 24
) (
  input  logic [SIZE_ACC-1:0]  i_acc,
  input  logic [SIZE_DATA-1:0] i_data,
  output logic [SIZE_ACC-1:0]  o_sum
`ifdef VEC_ACCUM_SAT_EN
  ,
  output logic                 o_ovf
`endif
);

  logic [SIZE_ACC-1:0] ext;
  logic [SIZE_ACC-1:0] raw;

  assign ext = SIZE_ACC'($signed(i_data));
  assign raw = i_acc + ext;

`ifdef VEC_ACCUM_SAT_EN
  logic ovf_pos;
  logic ovf_neg;

  // Two same-sign operands producing an opposite-sign result is a signed overflow.
  assign ovf_pos = !i_acc[SIZE_ACC-1] && !ext[SIZE_ACC-1] &&  raw[SIZE_ACC-1];
  assign ovf_neg =  i_acc[SIZE_ACC-1] &&  ext[SIZE_ACC-1] && !raw[SIZE_ACC-1];
  assign o_ovf   = ovf_pos || ovf_neg;

  always_comb begin
    o_sum = raw;
    if (ovf_pos) begin
      o_sum = {1'b0, {(SIZE_ACC-1){1'b1}}};
    end else if (ovf_neg) begin
      o_sum = {1'b1, {(SIZE_ACC-1){1'b0}}};
    end
  end
`else
  assign o_sum = raw;
`endif

endmodule

// File: rtl/vec_accum.sv
// rtl/vec_accum.sv - turns index beats into memory reads and sums the signed data; VEC_ACCUM_SAT_EN adds saturation and o_ovf
module vec_accum
  import vec_accum_pkg::*;
#(
  parameter int SIZE_ADDR = 8,
  parameter int SIZE_DATA = 16,
  parameter int SIZE_ACC  = 24
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_idx_en,
  input  logic [SIZE_ADDR-1:0] i_idx,
  input  logic                 i_idx_last,
  output logic                 o_rd_en,
  output logic [SIZE_ADDR-1:0] o_rd_addr,
  input  logic [SIZE_DATA-1:0] i_rd_data,
  output logic [SIZE_ACC-1:0]  o_sum,
  output logic [SIZE_ADDR:0]   o_count,
  output logic                 o_valid,
`ifdef VEC_ACCUM_SAT_EN
  output logic                 o_ovf,
`endif
  output logic                 o_busy
);

  state_e              state;
  logic                accept;
  logic                last_s1;
  logic [RD_LAT-1:0]   dv_sr;
  logic [RD_LAT-1:0]   last_sr;
  logic                dv;
  logic                dv_last;
  logic [SIZE_ACC-1:0] sum_next;
`ifdef VEC_ACCUM_SAT_EN
  logic                add_ovf;
`endif

  // A beat coinciding with i_start belongs to the aborted pass and is dropped.
  assign accept  = (state == RUN) && i_idx_en && !i_start;
  assign dv      = dv_sr[RD_LAT-1];
  assign dv_last = last_sr[RD_LAT-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_en   <= 1'b0;
      o_rd_addr <= '0;
      last_s1   <= 1'b0;
    end else if (i_start) begin
      o_rd_en   <= 1'b0;
      last_s1   <= 1'b0;
    end else begin
      o_rd_en <= accept;
      last_s1 <= accept && i_idx_last;
      if (accept) begin
        o_rd_addr <= i_idx;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dv_sr   <= '0;
      last_sr <= '0;
    end else if (i_start) begin
      dv_sr   <= '0;
      last_sr <= '0;
    end else begin
      dv_sr[0]   <= o_rd_en;
      last_sr[0] <= last_s1;
      for (int i = 1; i < RD_LAT; i++) begin
        dv_sr[i]   <= dv_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  vec_accum_add #(
    .SIZE_DATA (SIZE_DATA),
    .SIZE_ACC  (SIZE_ACC)
  ) u_add (
    .i_acc  (o_sum),
    .i_data (i_rd_data),
`ifdef VEC_ACCUM_SAT_EN
    .o_ovf  (add_ovf),
`endif
    .o_sum  (sum_next)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sum   <= '0;
      o_count <= '0;
`ifdef VEC_ACCUM_SAT_EN
      o_ovf   <= 1'b0;
`endif
    end else if (i_start) begin
      o_sum   <= '0;
      o_count <= '0;
`ifdef VEC_ACCUM_SAT_EN
      o_ovf   <= 1'b0;
`endif
    end else if (dv) begin
      o_sum   <= sum_next;
      o_count <= o_count + (SIZE_ADDR+1)'(1);
`ifdef VEC_ACCUM_SAT_EN
      o_ovf   <= o_ovf || add_ovf;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_start) begin
        state  <= RUN;
        o_busy <= 1'b1;
      end else begin
        case (state)
          IDLE:  state <= IDLE;
          RUN:   if (i_idx_en && i_idx_last) state <= DRAIN;
          DRAIN: if (dv && dv_last) begin
                   state   <= DONE;
                   o_valid <= 1'b1;
                   o_busy  <= 1'b0;
                 end
          DONE:  state <= IDLE;
          default: begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vec_accum.sv
// tb/tb_vec_accum.sv - checks vec_accum (24-bit and 16-bit accumulators) against constant vectors and an arithmetic model
module tb_vec_accum;

  localparam int SA  = 8;
  localparam int SD  = 16;
  localparam int SAC = 24;
  localparam int SB  = 16;

`ifdef VEC_ACCUM_SAT_EN
  localparam logic [15:0] OVF16_EXP = 16'h7FFF;
`else
  localparam logic [15:0] OVF16_EXP = 16'h8000;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_idx_en = 1'b0;
  logic          i_idx_last = 1'b0;
  logic [SA-1:0] i_idx = '0;

  logic           o_rd_en, o_rd_en_b;
  logic [SA-1:0]  o_rd_addr, o_rd_addr_b;
  logic [SD-1:0]  rd_data = '0, rd_data_b = '0;
  logic [SAC-1:0] o_sum;
  logic [SB-1:0]  o_sum_b;
  logic [SA:0]    o_count, o_count_b;
  logic           o_valid, o_valid_b, o_busy, o_busy_b;
`ifdef VEC_ACCUM_SAT_EN
  logic           o_ovf, o_ovf_b;
`endif

  vec_accum #(.SIZE_ADDR(SA), .SIZE_DATA(SD), .SIZE_ACC(SAC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_idx_en(i_idx_en),
    .i_idx(i_idx), .i_idx_last(i_idx_last), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .i_rd_data(rd_data), .o_sum(o_sum), .o_count(o_count), .o_valid(o_valid),
`ifdef VEC_ACCUM_SAT_EN
    .o_ovf(o_ovf),
`endif
    .o_busy(o_busy)
  );

  vec_accum #(.SIZE_ADDR(SA), .SIZE_DATA(SD), .SIZE_ACC(SB)) dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_idx_en(i_idx_en),
    .i_idx(i_idx), .i_idx_last(i_idx_last), .o_rd_en(o_rd_en_b), .o_rd_addr(o_rd_addr_b),
    .i_rd_data(rd_data_b), .o_sum(o_sum_b), .o_count(o_count_b), .o_valid(o_valid_b),
`ifdef VEC_ACCUM_SAT_EN
    .o_ovf(o_ovf_b),
`endif
    .o_busy(o_busy_b)
  );

  always #5 i_clk = ~i_clk;

  logic [SD-1:0] mem [0:255];
  always @(posedge i_clk) begin
    if (o_rd_en)   rd_data   <= mem[o_rd_addr];
    if (o_rd_en_b) rd_data_b <= mem[o_rd_addr_b];
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int             vcnt = 0, vcnt_b = 0, vcyc = 0, rdcnt = 0;
  logic [SAC-1:0] vsum;
  logic [SA:0]    vcount;
  logic [SB-1:0]  vsum_b;
  logic           vovf_b = 1'b0;
  always @(negedge i_clk) begin
    if (o_rd_en) rdcnt++;
    if (o_valid) begin
      vcnt++;
      vcyc   = cyc;
      vsum   = o_sum;
      vcount = o_count;
    end
    if (o_valid_b) begin
      vcnt_b++;
      vsum_b = o_sum_b;
`ifdef VEC_ACCUM_SAT_EN
      vovf_b = o_ovf_b;
`endif
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Called #1 into a cycle; leaves the bench #1 into the cycle after the last beat.
  task automatic run_beats(input int idxs[$], input int gap, input bit rnd_gap,
                           input bit with_last, output int last_c);
    last_c = cyc;
    for (int k = 0; k < idxs.size(); k++) begin
      int g;
      i_idx_en   = 1'b1;
      i_idx      = SA'(idxs[k]);
      i_idx_last = with_last && (k == idxs.size() - 1);
      last_c     = cyc;
      tick();
      i_idx_en   = 1'b0;
      i_idx_last = 1'b0;
      g = rnd_gap ? int'($urandom_range(0, 2)) : gap;
      if (k != idxs.size() - 1) repeat (g) tick();
    end
  endtask

  task automatic model(input int idxs[$], output logic [23:0] s24,
                       output logic [15:0] s16, output logic ovf);
    longint a = 0;
    longint b = 0;
    ovf = 1'b0;
    foreach (idxs[k]) begin
      longint v;
      v = longint'($signed(mem[idxs[k]]));
      a += v;
      b += v;
`ifdef VEC_ACCUM_SAT_EN
      if (b > 32767) begin
        b = 32767;
        ovf = 1'b1;
      end else if (b < -32768) begin
        b = -32768;
        ovf = 1'b1;
      end
`endif
    end
    s24 = a[23:0];
    s16 = b[15:0];
  endtask

  task automatic check_result(input string nm, input int v0, input int vb0, input int last_c,
                              input logic [23:0] e24, input logic [8:0] ecnt,
                              input logic [15:0] e16, input logic eovf);
    for (int t = 0; t < 12 && vcnt == v0; t++) tick();
    repeat (4) tick();
    chk({nm, ".valid_pulses"}, 64'(vcnt - v0), 64'd1);
    chk({nm, ".valid_pulses16"}, 64'(vcnt_b - vb0), 64'd1);
    chk({nm, ".latency"}, 64'(vcyc - last_c), 64'd3);
    chk({nm, ".sum"}, 64'(vsum), 64'(e24));
    chk({nm, ".count"}, 64'(vcount), 64'(ecnt));
    chk({nm, ".sum16"}, 64'(vsum_b), 64'(e16));
`ifdef VEC_ACCUM_SAT_EN
    chk({nm, ".ovf16"}, 64'(vovf_b), 64'(eovf));
`else
    if (eovf === 1'bx) $display("unexpected X flag in %s", nm);
`endif
  endtask

  typedef struct {
    int          n;
    int          gap;
    logic [15:0] v [4];
    logic [23:0] e_sum;
    logic [8:0]  e_cnt;
    logic [15:0] e_sum16;
    logic        e_ovf16;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int idxs[$];
    int v0, vb0, last_c, r0;
    logic [23:0] e24;
    logic [15:0] e16;
    logic eovf;

    #200000000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  initial begin
    int idxs[$];
    int v0, vb0, last_c, r0;
    logic [23:0] e24;
    logic [15:0] e16;
    logic eovf;

    for (int i = 0; i < 256; i++) mem[i] = '0;

    tbl[0] = '{4, 0, '{16'd1, 16'd2, 16'd3, 16'd4}, 24'd10, 9'd4, 16'h000A, 1'b0};
    tbl[1] = '{3, 1, '{16'hFFFB, 16'h0007, 16'hFFFF, 16'h0000}, 24'h000001, 9'd3, 16'h0001, 1'b0};
    tbl[2] = '{1, 0, '{16'h8000, 16'h0, 16'h0, 16'h0}, 24'hFF8000, 9'd1, 16'h8000, 1'b0};
    tbl[3] = '{2, 0, '{16'h7FFF, 16'h0001, 16'h0, 16'h0}, 24'h008000, 9'd2, OVF16_EXP, 1'b1};

    #3;
    chk("reset.rd_en", 64'(o_rd_en), 64'd0);
    chk("reset.rd_addr", 64'(o_rd_addr), 64'd0);
    chk("reset.sum", 64'(o_sum), 64'd0);
    chk("reset.count", 64'(o_count), 64'd0);
    chk("reset.valid", 64'(o_valid), 64'd0);
    chk("reset.busy", 64'(o_busy), 64'd0);
    #4 i_rst_n = 1'b1;
    tick();
    tick();

    // Beats while IDLE must not produce reads.
    r0 = rdcnt;
    i_idx_en = 1'b1;
    i_idx_last = 1'b1;
    repeat (3) tick();
    i_idx_en = 1'b0;
    i_idx_last = 1'b0;
    repeat (3) tick();
    chk("idle.ignored_beats", 64'(rdcnt - r0), 64'd0);

    for (int t = 0; t < 4; t++) begin
      idxs.delete();
      for (int i = 0; i < tbl[t].n; i++) begin
        mem[i] = tbl[t].v[i];
        idxs.push_back(i);
      end
      v0 = vcnt;
      vb0 = vcnt_b;
      pulse_start();
      chk($sformatf("tbl%0d.busy", t), 64'(o_busy), 64'd1);
      run_beats(idxs, tbl[t].gap, 1'b0, 1'b1, last_c);
      check_result($sformatf("tbl%0d", t), v0, vb0, last_c, tbl[t].e_sum, tbl[t].e_cnt,
                   tbl[t].e_sum16, tbl[t].e_ovf16);
      chk($sformatf("tbl%0d.busy_after", t), 64'(o_busy), 64'd0);
      chk($sformatf("tbl%0d.sum_hold", t), 64'(o_sum), 64'(tbl[t].e_sum));
    end

    // Restart mid-pass: two beats of 100 in flight when i_start arrives.
    mem[0] = 16'd100;
    mem[1] = 16'd100;
    for (int i = 4; i < 8; i++) mem[i] = 16'd1;
    v0 = vcnt;
    vb0 = vcnt_b;
    pulse_start();
    idxs = '{0, 1};
    run_beats(idxs, 0, 1'b0, 1'b0, last_c);
    pulse_start();
    idxs = '{4, 5, 6, 7};
    run_beats(idxs, 0, 1'b0, 1'b1, last_c);
    check_result("restart", v0, vb0, last_c, 24'd4, 9'd4, 16'd4, 1'b0);

    // Reset between the last beat and o_valid.
    for (int i = 0; i < 4; i++) mem[i] = 16'd9;
    v0 = vcnt;
    pulse_start();
    idxs = '{0, 1, 2, 3};
    run_beats(idxs, 0, 1'b0, 1'b1, last_c);
    tick();
    i_rst_n = 1'b0;
    #1;
    chk("rst_drain.rd_en", 64'(o_rd_en), 64'd0);
    chk("rst_drain.sum", 64'(o_sum), 64'd0);
    chk("rst_drain.count", 64'(o_count), 64'd0);
    chk("rst_drain.valid", 64'(o_valid), 64'd0);
    chk("rst_drain.busy", 64'(o_busy), 64'd0);
    #2 i_rst_n = 1'b1;
    repeat (8) tick();
    chk("rst_drain.no_valid", 64'(vcnt - v0), 64'd0);

    // i_start in the o_valid cycle: pulse survives, clear lands next cycle.
    for (int i = 0; i < 3; i++) mem[i] = 16'd5;
    v0 = vcnt;
    pulse_start();
    idxs = '{0, 1, 2};
    run_beats(idxs, 0, 1'b0, 1'b1, last_c);
    tick();
    tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("start_on_valid.pulse", 64'(vcnt - v0), 64'd1);
    chk("start_on_valid.final_sum", 64'(vsum), 64'd15);
    chk("start_on_valid.cleared_sum", 64'(o_sum), 64'd0);
    chk("start_on_valid.cleared_cnt", 64'(o_count), 64'd0);
    chk("start_on_valid.busy", 64'(o_busy), 64'd1);
    v0 = vcnt;
    vb0 = vcnt_b;
    idxs = '{2, 1};
    run_beats(idxs, 0, 1'b0, 1'b1, last_c);
    check_result("start_on_valid.next", v0, vb0, last_c, 24'd10, 9'd2, 16'd10, 1'b0);

    // Randomised passes against the arithmetic model.
    for (int r = 0; r < 20; r++) begin
      int n;
      n = int'($urandom_range(1, 12));
      idxs.delete();
      for (int k = 0; k < n; k++) begin
        int ix;
        ix = int'($urandom_range(0, 255));
        mem[ix] = 16'($urandom);
        idxs.push_back(ix);
      end
      model(idxs, e24, e16, eovf);
      v0 = vcnt;
      vb0 = vcnt_b;
      pulse_start();
      run_beats(idxs, 0, 1'b1, 1'b1, last_c);
      check_result($sformatf("rnd%0d", r), v0, vb0, last_c, e24, 9'(n), e16, eovf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vec_accum.md
# vec_accum

Downstream consumer of the loop-index counter. Turns each enabled index into a read of a synchronous data memory, sums the returned signed elements into a wide accumulator, and reports the sum with a one-cycle valid pulse once the last index's data has been added. The block sits between the loop-index counter and the result/writeback stage of a vector-reduction pass.

## Interface
- SIZE_ADDR, 8, index/address width; matches the loop-index counter.
- SIZE_DATA, 16, memory element width, signed two's complement.
- SIZE_ACC, 24, accumulator width; must be ≥ SIZE_DATA.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  single-cycle pulse: clear the accumulator and begin a new pass.
- i_idx_en  in  1  index beat valid.
- i_idx  in  SIZE_ADDR  element index for this beat.
- i_idx_last  in  1  qualifies the final beat; only meaningful when i_idx_en=1.
- o_rd_en  out  1  memory read strobe.
- o_rd_addr  out  SIZE_ADDR  memory read address.
- i_rd_data  in  SIZE_DATA  memory data; valid exactly 1 cycle after o_rd_en.
- o_sum  out  SIZE_ACC  accumulated sum.
- o_count  out  SIZE_ADDR+1  number of elements accumulated in the current pass.
- o_valid  out  1  one-cycle pulse: o_sum and o_count are final.
- o_busy  out  1  high in RUN and DRAIN.
- o_ovf  out  1  sticky overflow flag; exists only with VEC_ACCUM_SAT_EN.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on i_start.
  - RUN → DRAIN on a beat with i_idx_en & i_idx_last.
  - DRAIN → DONE when the last beat's data is accumulated.
  - DONE → IDLE unconditionally after 1 cycle.
  - i_start in any state → RUN.
- i_start clears o_sum, o_count, o_ovf and all in-flight pipeline valids. An aborted pass never raises o_valid.
- i_start has priority over a beat presented in the same cycle. That beat is dropped.
- Beats are accepted only in RUN. i_idx_en in IDLE, DRAIN or DONE is ignored.
- Stage 1 (registered): o_rd_en <= accepted beat; o_rd_addr <= i_idx; the last flag is piped alongside.
- Stage 2: a data-valid flag (delayed o_rd_en) qualifies i_rd_data.
- Stage 3: o_sum <= o_sum + sign_extend(i_rd_data); o_count increments.
- Gaps between beats are allowed. Back-to-back beats are accepted every cycle, with no stall and no backpressure.
- Arithmetic: data is sign-extended to SIZE_ACC. Without the macro the sum wraps modulo 2^SIZE_ACC.
- o_sum and o_count hold their values after DONE until the next i_start or reset.

## Timing
- Reset values: o_rd_en 0, o_rd_addr 0, o_sum 0, o_count 0, o_valid 0, o_busy 0, o_ovf 0; state IDLE.
- A beat presented in cycle c produces:
  - o_rd_en high in cycle c+1;
  - data sampled at the end of c+2;
  - o_sum and o_count updated in cycle c+3.
- Last beat in cycle c: o_valid high in cycle c+3 only, with state DONE in c+3 and IDLE in c+4.
- o_busy is high from the cycle after i_start through the cycle before o_valid.
- Reset mid-pass: all outputs return to reset values immediately (asynchronous). No o_valid is produced.
- i_start in the o_valid cycle: o_valid still pulses for that cycle, and the clear takes effect the next cycle.

## Configuration
- VEC_ACCUM_SAT_EN defined:
  - the add saturates to the signed max or min of SIZE_ACC;
  - the o_ovf port exists and sets on any saturating add;
  - o_ovf is sticky until i_start or reset.
- VEC_ACCUM_SAT_EN undefined: the add wraps and the o_ovf port is absent.

## Structure
- Package vec_accum_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the read-latency constant RD_LAT=1.
- One sub-module, vec_accum_add: a combinational signed add of the sign-extended element into the accumulator. It contains the saturation/overflow logic under VEC_ACCUM_SAT_EN and is instantiated once in stage 3.

## Test plan
- Basic pass: start, then beats idx 0..3 back-to-back with mem[i]={1,2,3,4}, last on idx 3 -> o_valid exactly 3 cycles after the last beat, o_sum=10, o_count=4.
- Gapped beats: idx 0..2 with one idle cycle between beats, mem={-5,7,-1} -> o_sum=1 (0x000001), o_count=3, a single o_valid pulse.
- Single element: start, then one beat idx 0 with last set, mem[0]=0x8000 -> o_sum=0xFF8000, o_count=1.
- Restart mid-pass: after 2 of 4 beats, i_start, then a full 4-beat pass of value 1 -> one o_valid only, o_sum=4, no stale data.
- Reset mid-DRAIN: assert i_rst_n=0 between the last beat and o_valid -> all outputs 0, no o_valid after release.
- Overflow, with SIZE_ACC=16 and beats mem={0x7FFF, 1}:
  - macro defined -> o_sum=0x7FFF, o_ovf=1;
  - macro undefined -> o_sum=0x8000.
